mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
Time-shares one external 6x6 array multiplier among NREQ requesters. The multiplier has a 12-bit CLA final adder and exact/approximate partial-product cells. The block arbitrates round-robin, drives the multiplier operands and the approx-select line, and waits a fixed multicycle settle time. It then returns the 12-bit product with the requester ID over a valid/ready response channel. It sits between the PicoSoC co-processor bus glue and the combinational multiplier array.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 6, operand width; product width is 2*WIDTH
MUL_WAIT, 2, settle cycles allowed for the combinational multiplier path (1..15)

Ports:
clk  in  1  clock; all state updates on the rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester grant/accept, one-hot or zero
req_a  in  NREQ*WIDTH  flattened operand A; requester i at [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  flattened operand B, same packing
cfg_approx  in  NREQ  per-requester select: 1 = approximate cells, 0 = exact
mul_a  out  WIDTH  operand A to shared multiplier (registered)
mul_b  out  WIDTH  operand B to shared multiplier (registered)
mul_approx  out  1  approx select to shared multiplier (registered)
mul_p  in  2*WIDTH  product from shared multiplier
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  clog2(NREQ)  requester index of the response
rsp_data  out  2*WIDTH  captured product
busy  out  1  high in any state other than IDLE
op_count  out  16  completed responses, saturates at 16'hFFFF

Behaviour:
- Reset (resetn low, asynchronous): state IDLE, rr pointer 0, and all outputs low.
  - Zeroed outputs: req_ready, mul_a, mul_b, mul_approx, rsp_valid, rsp_id, rsp_data, busy and op_count.
  - Reset mid-operation aborts the transaction: no response is produced and the requester gets no second ready.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i] high, scanning ptr, ptr+1, ..., wrapping modulo NREQ.
  - req_ready[winner] is driven combinationally high only in IDLE. It is zero when no request is pending.
  - On req_valid[w] & req_ready[w]:
    - register mul_a, mul_b and mul_approx from requester w (mul_approx = cfg_approx[w]);
    - register rsp_id = w;
    - load the wait counter with MUL_WAIT;
    - go to WAIT.
- WAIT:
  - The counter decrements each cycle; mul_a, mul_b and mul_approx are held stable.
  - When the counter reaches 1: capture mul_p into rsp_data, set rsp_valid, go to RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held until rsp_ready is high.
  - On handshake: clear rsp_valid, set ptr = (rsp_id+1) mod NREQ, increment op_count (saturating), go to IDLE.
  - No new grant is issued in the handshake cycle; the earliest next req_ready is the following cycle.
- Latency: accept edge at cycle 0 -> rsp_valid high after cycle MUL_WAIT. Minimum issue interval is MUL_WAIT+2 cycles.
- mul_a and mul_b retain their last values in IDLE; they are not zeroed between operations.
- A requester may drop req_valid before being granted. The grant is re-evaluated every IDLE cycle with no penalty.
- Changes on req_a, req_b or cfg_approx after acceptance have no effect on the transaction in flight.
- Simultaneous requests: exactly one is granted. Pointer fairness guarantees every continuously-valid requester is served within NREQ transactions.
- Arithmetic: the block does not compute; rsp_data is bit-exact mul_p as sampled at the capture edge.

Test Plan:
- Single request, MUL_WAIT=2: req 1 with a=5, b=7, cfg_approx[1]=0, exact multiplier model -> req_ready[1] high 1 cycle; rsp_valid 2 cycles after accept; rsp_id=1, rsp_data=35; op_count=1.
- Round-robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_id matches; op_count=5.
- Wrap priority: after serving req 2 (ptr=3), assert req 0 and req 3 together -> req 3 is granted first, then req 0.
- Backpressure: rsp_ready low for 5 cycles in RESP with rsp_data=63*63=3969 -> rsp_valid and rsp_data stay stable; no req_ready asserted; after rsp_ready the next grant comes 1 cycle later.
- Approx path: cfg_approx[2]=1, a=b=63 -> mul_approx high from accept through capture; rsp_data equals the approximate-model output, not 3969.
- Reset mid-WAIT: resetn low during WAIT -> outputs zero immediately; no rsp_valid after release; the next grant starts from requester 0.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul_share_arbiter
//
// Time-shares one external combinational WIDTH x WIDTH multiplier among NREQ
// requesters. A round-robin arbiter picks one pending request in IDLE. It
// registers that requester's operands and approx-select onto the multiplier
// inputs, then waits MUL_WAIT cycles for the multiplier path to settle. It
// then captures the product and offers it, tagged with the requester index,
// on a valid/ready response channel.
//
// Ports:
//   clk         rising-edge clock
//   resetn      asynchronous active-low reset
//   req_valid   per-requester request valid                  [NREQ]
//   req_ready   per-requester grant, one-hot or zero, IDLE   [NREQ]
//   req_a       flattened operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b       flattened operand B, same packing
//   cfg_approx  per-requester approx select (1 = approximate cells)
//   mul_a       registered operand A to the shared multiplier
//   mul_b       registered operand B to the shared multiplier
//   mul_approx  registered approx select to the shared multiplier
//   mul_p       product returned by the shared multiplier   [2*WIDTH]
//   rsp_valid   response valid
//   rsp_ready   response accept
//   rsp_id      requester index of the response
//   rsp_data    captured product
//   busy        high whenever the FSM is not in IDLE
//   op_count    completed responses, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module mul_share_arbiter #(
   parameter  int NREQ     = 4,
   parameter  int WIDTH    = 6,
   parameter  int MUL_WAIT = 2,
   localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int PW       = 2 * WIDTH
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       cfg_approx,
   output logic [WIDTH-1:0]      mul_a,
   output logic [WIDTH-1:0]      mul_b,
   output logic                  mul_approx,
   input  logic [PW-1:0]         mul_p,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [PW-1:0]         rsp_data,
   output logic                  busy,
   output logic [15:0]           op_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);
   localparam logic [IDW:0]   NREQ_EXT = (IDW + 1)'(NREQ);
   localparam logic [3:0]     WAIT_LD  = 4'(MUL_WAIT);

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   state_t           state_q,      state_d;
   logic [IDW-1:0]   ptr_q,        ptr_d;
   logic [3:0]       cnt_q,        cnt_d;
   logic [WIDTH-1:0] mul_a_q,      mul_a_d;
   logic [WIDTH-1:0] mul_b_q,      mul_b_d;
   logic             mul_approx_q, mul_approx_d;
   logic             rsp_valid_q,  rsp_valid_d;
   logic [IDW-1:0]   rsp_id_q,     rsp_id_d;
   logic [PW-1:0]    rsp_data_q,   rsp_data_d;
   logic [15:0]      op_count_q,   op_count_d;

   // Arbitration result
   logic             grant_found;
   logic [IDW-1:0]   grant_idx;

   // --------------------------------------------------------------------------
   // Round-robin winner: first valid requester scanning ptr, ptr+1, ...
   // Candidate index is ptr+k folded once into 0..NREQ-1; both terms are
   // below NREQ, so a single conditional subtract is sufficient.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable written in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         logic [IDW:0]   sum;
         logic [IDW-1:0] cand;
         sum = {1'b0, ptr_q} + (IDW + 1)'(k);
         if (sum >= NREQ_EXT) begin
            sum = sum - NREQ_EXT;
         end
         cand = sum[IDW-1:0];
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Grant is offered only in IDLE. It is also gated by resetn so that
   // req_ready reads zero for the whole time reset is asserted, even though
   // the FSM already sits in IDLE then.
   always_comb begin
      req_ready = '0;
      if (resetn && (state_q == S_IDLE) && grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and datapath logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      mul_a_d      = mul_a_q;
      mul_b_d      = mul_b_q;
      mul_approx_d = mul_approx_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      op_count_d   = op_count_q;

      unique case (state_q)
         S_IDLE: begin
            // A raised req_ready always coincides with req_valid of the
            // winner, so finding a winner in IDLE is the accept condition.
            if (grant_found) begin
               mul_a_d      = req_a[grant_idx*WIDTH +: WIDTH];
               mul_b_d      = req_b[grant_idx*WIDTH +: WIDTH];
               mul_approx_d = cfg_approx[grant_idx];
               rsp_id_d     = grant_idx;
               cnt_d        = WAIT_LD;
               state_d      = S_WAIT;
            end
         end

         S_WAIT: begin
            // Operands stay frozen; the product is sampled on the edge where
            // the counter is 1, i.e. MUL_WAIT edges after the accept edge.
            if (cnt_q == 4'd1) begin
               rsp_data_d  = mul_p;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               ptr_d       = (rsp_id_q == LAST_ID) ? '0 : rsp_id_q + 1'b1;
               if (op_count_q != 16'hFFFF) begin
                  op_count_d = op_count_q + 16'd1;
               end
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Registers. Asynchronous reset aborts any transaction in flight.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      if (!resetn) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         cnt_q        <= '0;
         mul_a_q      <= '0;
         mul_b_q      <= '0;
         mul_approx_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         op_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
         mul_approx_q <= mul_approx_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         op_count_q   <= op_count_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign mul_a      = mul_a_q;
   assign mul_b      = mul_b_q;
   assign mul_approx = mul_approx_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_data   = rsp_data_q;
   assign busy       = (state_q != S_IDLE);
   assign op_count   = op_count_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_share_arbiter
//
// Directed bench for mul_share_arbiter (NREQ=4, WIDTH=6, MUL_WAIT=2).
// Stimulus pushes the expected grant index and expected response into
// queues. A monitor on the falling edge pops and compares them whenever a
// request handshake or a response handshake is presented. The shared
// multiplier is modelled here: exact, or approximate with all partial-product
// bits in columns 0..3 dropped.
// -----------------------------------------------------------------------------
module tb_mul_share_arbiter;

   localparam int NREQ     = 4;
   localparam int WIDTH    = 6;
   localparam int MUL_WAIT = 2;
   localparam int IDW      = 2;
   localparam int PW       = 12;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [PW-1:0]  data;
   } rsp_t;

   logic                  clk = 1'b0;
   logic                  resetn;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       cfg_approx;
   logic [WIDTH-1:0]      mul_a;
   logic [WIDTH-1:0]      mul_b;
   logic                  mul_approx;
   logic [PW-1:0]         mul_p;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [PW-1:0]         rsp_data;
   logic                  busy;
   logic [15:0]           op_count;

   int errors = 0;
   int checks = 0;

   rsp_t           exp_rsp[$];
   logic [IDW-1:0] exp_grant[$];
   rsp_t           mon_rsp;
   logic [IDW-1:0] mon_gid;
   logic [IDW-1:0] mon_exp_gid;
   logic [NREQ-1:0] mon_acc;

   always #5 clk = ~clk;

   mul_share_arbiter #(
      .NREQ    (NREQ),
      .WIDTH   (WIDTH),
      .MUL_WAIT(MUL_WAIT)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .cfg_approx(cfg_approx),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_approx(mul_approx),
      .mul_p     (mul_p),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .op_count  (op_count)
   );

   // Shared multiplier model
   function automatic logic [PW-1:0] mul_model(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic apx);
      logic [PW-1:0] acc;
      acc = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            if (a[i] && b[j] && (!apx || (i + j) >= 4)) begin
               acc = acc + (PW'(1) << (i + j));
            end
         end
      end
      return acc;
   endfunction

   assign mul_p = mul_model(mul_a, mul_b, mul_approx);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // --------------------------------------------------------------------------
   // Monitor: compares every grant and every response handshake
   // --------------------------------------------------------------------------
   always @(negedge clk) begin
      if (resetn) begin
         if (rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got id=%0d data=%0d, required no response at %0t", rsp_id, rsp_data, $time);
            end else begin
               mon_rsp = exp_rsp.pop_front();
               check("rsp_id", 32'(rsp_id), 32'(mon_rsp.id));
               check("rsp_data", 32'(rsp_data), 32'(mon_rsp.data));
            end
         end
         mon_acc = req_valid & req_ready;
         if (mon_acc != '0) begin
            check("grant_onehot", 32'($onehot(mon_acc)), 32'd1);
            mon_gid = '0;
            for (int i = NREQ - 1; i >= 0; i--) begin
               if (mon_acc[i]) mon_gid = IDW'(i);
            end
            if (exp_grant.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL grant_unexpected: got grant %0d, required none at %0t", mon_gid, $time);
            end else begin
               mon_exp_gid = exp_grant.pop_front();
               check("grant_id", 32'(mon_gid), 32'(mon_exp_gid));
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Stimulus helpers
   // --------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      req_a[id*WIDTH +: WIDTH] = a;
      req_b[id*WIDTH +: WIDTH] = b;
   endtask

   task automatic expect_txn(input int id, input int data);
      rsp_t r;
      r.id   = IDW'(id);
      r.data = PW'(data);
      exp_grant.push_back(IDW'(id));
      exp_rsp.push_back(r);
   endtask

   // Wait for n accepted grants; optionally drop each accepted request.
   task automatic run_grants(input int n, input bit drop);
      int got;
      logic [NREQ-1:0] acc;
      got = 0;
      for (int c = 0; c < 200 && got < n; c++) begin
         #1;
         acc = req_valid & req_ready;
         tick();
         if (acc != '0) begin
            got++;
            if (drop) req_valid = req_valid & ~acc;
         end
      end
      check("grant_timeout", 32'(got), 32'(n));
   endtask

   task automatic wait_drain(input int budget);
      int c;
      c = 0;
      while ((exp_rsp.size() != 0 || busy) && c < budget) begin
         tick();
         c++;
      end
      check("drain_timeout", 32'(exp_rsp.size() != 0 || busy), 32'd0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_req_ready"},  32'(req_ready),  32'd0);
      check({tag, "_mul_a"},      32'(mul_a),      32'd0);
      check({tag, "_mul_b"},      32'(mul_b),      32'd0);
      check({tag, "_mul_approx"}, 32'(mul_approx), 32'd0);
      check({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
      check({tag, "_rsp_id"},     32'(rsp_id),     32'd0);
      check({tag, "_rsp_data"},   32'(rsp_data),   32'd0);
      check({tag, "_busy"},       32'(busy),       32'd0);
      check({tag, "_op_count"},   32'(op_count),   32'd0);
   endtask

   task automatic pulse_reset();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      tick();
   endtask

   // --------------------------------------------------------------------------
   // Directed sequence
   // --------------------------------------------------------------------------
   initial begin
      resetn     = 1'b0;
      req_valid  = '1;
      req_a      = '0;
      req_b      = '0;
      cfg_approx = '0;
      rsp_ready  = 1'b1;

      // Reset state, with all requests pending to show req_ready is held low
      #12;
      check_zero("reset");
      req_valid = '0;
      tick();
      resetn = 1'b1;
      tick();

      // Single request: req 1, 5*7, exact
      set_ops(1, 6'd5, 6'd7);
      expect_txn(1, 35);
      req_valid = 4'b0010;
      #1;
      check("t1_req_ready", 32'(req_ready), 32'b0010);
      tick();                              // accept edge
      req_valid = '0;
      #1;
      check("t1_ready_drop", 32'(req_ready), 32'd0);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_mul_a", 32'(mul_a), 32'd5);
      check("t1_mul_b", 32'(mul_b), 32'd7);
      check("t1_mul_approx", 32'(mul_approx), 32'd0);
      check("t1_valid_c0", 32'(rsp_valid), 32'd0);
      tick();
      check("t1_valid_c1", 32'(rsp_valid), 32'd0);
      tick();
      check("t1_valid_c2", 32'(rsp_valid), 32'd1);
      check("t1_rsp_data", 32'(rsp_data), 32'd35);
      tick();                              // response handshake edge
      check("t1_valid_after", 32'(rsp_valid), 32'd0);
      check("t1_op_count", 32'(op_count), 32'd1);
      check("t1_busy_after", 32'(busy), 32'd0);

      // Round-robin from a fresh pointer: 0,1,2,3,0
      pulse_reset();
      set_ops(0, 6'd3,  6'd4);
      set_ops(1, 6'd10, 6'd11);
      set_ops(2, 6'd63, 6'd1);
      set_ops(3, 6'd17, 6'd20);
      expect_txn(0, 12);
      expect_txn(1, 110);
      expect_txn(2, 63);
      expect_txn(3, 340);
      expect_txn(0, 12);
      req_valid = 4'hF;
      run_grants(5, 1'b0);
      req_valid = '0;
      wait_drain(60);
      check("rr_op_count", 32'(op_count), 32'd5);

      // Wrap priority: serve req 2 (ptr -> 3), then 0 and 3 together
      set_ops(2, 6'd9, 6'd9);
      expect_txn(2, 81);
      req_valid = 4'b0100;
      run_grants(1, 1'b1);
      wait_drain(20);
      set_ops(3, 6'd33, 6'd2);
      set_ops(0, 6'd8,  6'd8);
      expect_txn(3, 66);
      expect_txn(0, 64);
      req_valid = 4'b1001;
      run_grants(2, 1'b1);
      wait_drain(30);
      check("wrap_op_count", 32'(op_count), 32'd8);

      // Backpressure: 63*63 held for 5 cycles with req 1 pending
      rsp_ready = 1'b0;
      set_ops(0, 6'd63, 6'd63);
      expect_txn(0, 3969);
      req_valid = 4'b0001;
      run_grants(1, 1'b1);
      tick();
      tick();
      set_ops(1, 6'd6, 6'd7);
      expect_txn(1, 42);
      req_valid = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp_data", 32'(rsp_data), 32'd3969);
         check("bp_no_ready", 32'(req_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_hs_no_ready", 32'(req_ready), 32'd0);
      tick();                              // response handshake edge
      check("bp_valid_clear", 32'(rsp_valid), 32'd0);
      check("bp_next_ready", 32'(req_ready), 32'b0010);
      run_grants(1, 1'b1);
      wait_drain(20);
      check("bp_op_count", 32'(op_count), 32'd10);

      // Approximate path: 63*63 with columns 0..3 dropped -> 3969 - 49 = 3920
      set_ops(2, 6'd63, 6'd63);
      cfg_approx = 4'b0100;
      expect_txn(2, 3920);
      req_valid = 4'b0100;
      run_grants(1, 1'b1);                 // returns just after accept edge
      check("ap_mul_approx_c0", 32'(mul_approx), 32'd1);
      check("ap_mul_a_c0", 32'(mul_a), 32'd63);
      cfg_approx = '0;                     // changes after acceptance
      set_ops(2, 6'd1, 6'd1);
      tick();
      check("ap_mul_approx_c1", 32'(mul_approx), 32'd1);
      check("ap_mul_b_c1", 32'(mul_b), 32'd63);
      check("ap_valid_c1", 32'(rsp_valid), 32'd0);
      tick();
      check("ap_mul_approx_cap", 32'(mul_approx), 32'd1);
      check("ap_valid_cap", 32'(rsp_valid), 32'd1);
      check("ap_rsp_data", 32'(rsp_data), 32'd3920);
      wait_drain(20);
      check("ap_op_count", 32'(op_count), 32'd11);

      // Reset during WAIT: transaction aborted, pointer back to 0
      set_ops(3, 6'd2, 6'd3);
      exp_grant.push_back(IDW'(3));
      req_valid = 4'b1000;
      run_grants(1, 1'b1);
      check("rw_busy", 32'(busy), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      check_zero("rw");
      tick();
      tick();
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rw_no_rsp", 32'(rsp_valid), 32'd0);
      end
      set_ops(0, 6'd4, 6'd5);
      expect_txn(0, 20);
      req_valid = 4'hF;
      run_grants(1, 1'b0);
      req_valid = '0;
      wait_drain(20);
      check("rw_op_count", 32'(op_count), 32'd1);

      check("grant_queue_left", 32'(exp_grant.size()), 32'd0);
      check("rsp_queue_left", 32'(exp_rsp.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
